// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per step over a
// req/ready handshake and holds it for decode until the datapath advances.
//
// state | meaning
// ------+-------------------------------------------------------------
// RST   | first cycle after reset release, no request yet
// FETCH | imem_req high at pc, waiting for imem_ready
// HOLD  | instr valid for decode, waiting for advance to update pc
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        pc_src,
    input  logic [1:0]  jump,
    input  logic [15:0] imm,
    input  logic [25:0] jump_target,
    input  logic [31:0] reg_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misalign_fault,
    output logic        illegal_jump,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_J   = 2'b01;
    localparam logic [1:0] JMP_JR  = 2'b10;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        fetch_done;
    logic        retire;
    logic        misalign_nxt;
    logic        illegal_nxt;

    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;
    assign branch_off = {{14{imm[15]}}, imm, 2'b00};

    // pc_src is only consulted on the sequential/branch path, so an unknown
    // value during j/jr/illegal cannot reach pc.
    always_comb begin
        next_pc      = pc_plus4;
        misalign_nxt = 1'b0;
        illegal_nxt  = 1'b0;
        case (jump)
            JMP_J:   next_pc = {pc_plus4[31:28], jump_target, 2'b00};
            JMP_JR: begin
                next_pc      = {reg_target[31:2], 2'b00};
                misalign_nxt = (reg_target[1:0] != 2'b00);
            end
            JMP_SEQ: begin
                if (pc_src) begin
                    next_pc = pc_plus4 + branch_off;
                end
            end
            default: illegal_nxt = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        fetch_done = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_RST: state_nxt = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    fetch_done = 1'b1;
                    state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (advance) begin
                    retire    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            instr          <= 32'd0;
            instr_valid    <= 1'b0;
            misalign_fault <= 1'b0;
            illegal_jump   <= 1'b0;
            fetch_count    <= 32'd0;
        end else begin
            misalign_fault <= retire & misalign_nxt;
            illegal_jump   <= retire & illegal_nxt;
            if (fetch_done) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        advance = 1'b0;
    logic        pc_src = 1'b0;
    logic [1:0]  jump = 2'b00;
    logic [15:0] imm = 16'd0;
    logic [25:0] jump_target = 26'd0;
    logic [31:0] reg_target = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misalign_fault;
    logic        illegal_jump;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .advance(advance), .pc_src(pc_src),
        .jump(jump), .imm(imm), .jump_target(jump_target),
        .reg_target(reg_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc),
        .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
        .misalign_fault(misalign_fault), .illegal_jump(illegal_jump),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) + 32'h13;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the program counter as a plain number and a "holding an
    // instruction" flag; next address is computed from the jump rules.
    logic        m_started = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_cnt = 32'd0;
    logic        m_mis = 1'b0;
    logic        m_ill = 1'b0;

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] j,
                                               input logic br, input logic [15:0] off,
                                               input logic [25:0] jt, input logic [31:0] rt);
        logic [31:0] seq;
        int          words;
        seq   = cur + 32'd4;
        words = $signed(off);
        case (j)
            2'd1:    return (seq & 32'hF000_0000) | ({6'd0, jt} << 2);
            2'd2:    return rt & 32'hFFFF_FFFC;
            2'd0:    return br ? seq + 32'(words * 4) : seq;
            default: return seq;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_started = 1'b0; m_valid = 1'b0; m_pc = 32'd0; m_instr = 32'd0;
            m_cnt = 32'd0; m_mis = 1'b0; m_ill = 1'b0;
        end else begin
            m_mis = 1'b0;
            m_ill = 1'b0;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (!m_valid) begin
                if (imem_ready) begin
                    m_instr = mem_word(m_pc);
                    m_valid = 1'b1;
                end
            end else if (advance) begin
                m_mis   = (jump == 2'd2) && (reg_target[1:0] != 2'd0);
                m_ill   = (jump == 2'd3);
                m_pc    = model_next(m_pc, jump, pc_src, imm, jump_target, reg_target);
                m_valid = 1'b0;
                m_cnt   = m_cnt + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        if ($time > 2) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_started && !m_valid});
            chk("imem_addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr", instr, m_instr);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            chk("misalign_fault", {31'd0, misalign_fault}, {31'd0, m_mis});
            chk("illegal_jump", {31'd0, illegal_jump}, {31'd0, m_ill});
            chk("fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hold();
        int n;
        n = 0;
        while (!instr_valid && n < 50) begin
            tick();
            n++;
        end
        if (!instr_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_hold: instr_valid never rose within 50 cycles");
        end
    endtask

    task automatic do_adv(input logic [1:0] j, input logic br, input logic [15:0] off,
                          input logic [25:0] jt, input logic [31:0] rt);
        wait_hold();
        jump = j; pc_src = br; imm = off; jump_target = jt; reg_target = rt;
        advance = 1'b1;
        tick();
        advance = 1'b0; pc_src = 1'b0; jump = 2'b00;
    endtask

    logic [31:0] held_pc;
    logic [31:0] held_instr;

    initial begin
        #1 reset = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Zero-wait memory, advance tied high: 0x0, 0x4, 0x8 then pc = 0xC.
        advance = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fetch_count == 32'd3) break;
        end
        advance = 1'b0;
        chk("seq_count", fetch_count, 32'd3);
        chk("seq_pc", pc, 32'h0000_000C);

        // Backward branch of -1 word from 0x10 lands on 0x10; memory waits 3 cycles.
        do_adv(2'b01, 1'b0, 16'd0, 26'h4, 32'd0);
        chk("j_pc10", pc, 32'h0000_0010);
        wait_hold();
        imem_ready = 1'b0;
        jump = 2'b00; pc_src = 1'b1; imm = 16'hFFFF; advance = 1'b1;
        tick();
        advance = 1'b0; pc_src = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h0000_0010);
            if (i == 3) imem_ready = 1'b1;
            tick();
        end
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
        chk("wait_req_low", {31'd0, imem_req}, 32'd0);

        // j keeps the top nibble of pc+4; pc_src high must not matter.
        do_adv(2'b10, 1'b0, 16'd0, 26'd0, 32'h1000_0000);
        chk("jr_pc", pc, 32'h1000_0000);
        do_adv(2'b01, 1'b1, 16'h7FFF, 26'h000_0040, 32'd0);
        chk("j_pc", pc, 32'h1000_0100);

        // Misaligned jr and illegal jump each pulse their fault once.
        do_adv(2'b10, 1'b0, 16'd0, 26'd0, 32'h0000_2003);
        chk("mis_pc", pc, 32'h0000_2000);
        chk("mis_pulse", {31'd0, misalign_fault}, 32'd1);
        tick();
        chk("mis_clear", {31'd0, misalign_fault}, 32'd0);
        do_adv(2'b01, 1'b0, 16'd0, 26'h8, 32'd0);
        chk("j_pc20", pc, 32'h0000_0020);
        do_adv(2'b11, 1'b1, 16'h0004, 26'd0, 32'd0);
        chk("ill_pc", pc, 32'h0000_0024);
        chk("ill_pulse", {31'd0, illegal_jump}, 32'd1);
        tick();
        chk("ill_clear", {31'd0, illegal_jump}, 32'd0);

        // Hold without advance, then reset in the middle of a stalled fetch.
        wait_hold();
        held_pc = pc;
        held_instr = instr;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_pc", pc, held_pc);
            chk("hold_instr", instr, held_instr);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ready = 1'b0;
        do_adv(2'b00, 1'b0, 16'd0, 26'd0, 32'd0);
        tick();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_count", fetch_count, 32'd0);
        imem_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("late_ready_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ready_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("first_fetch_valid", {31'd0, instr_valid}, 32'd1);

        // Sequential wrap from the top of the address space.
        do_adv(2'b10, 1'b0, 16'd0, 26'd0, 32'hFFFF_FFFC);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        do_adv(2'b00, 1'b0, 16'd0, 26'd0, 32'd0);
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_count", fetch_count, 32'd2);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the single-cycle control unit. Holds the PC and fetches one instruction word per step from instruction memory through a req/ready handshake. Presents the instruction to decode until the downstream datapath asserts advance. On advance, computes the next PC from the control unit's pc_src/jump outputs, the branch offset, the jump target and the register target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
advance  input  1  current instruction has executed; PC update inputs are valid this cycle.
pc_src  input  1  branch taken, from control unit; ignored when jump != 2'b00.
jump  input  2  00 = sequential/branch, 01 = j (immediate target), 10 = jr (register target), 11 = illegal.
imm  input  16  instr[15:0] branch offset, signed word count.
jump_target  input  26  instr[25:0].
reg_target  input  32  rs value for jr.
imem_req  output  1  instruction read request.
imem_addr  output  32  read address; equals pc.
imem_ready  input  1  memory has returned data on imem_rdata this cycle.
imem_rdata  input  32  instruction word.
pc  output  32  address of the held or pending instruction.
pc_plus4  output  32  pc + 4, for the link/branch datapath.
instr  output  32  held instruction word.
instr_valid  output  1  instr is valid for decode.
misalign_fault  output  1  one-cycle pulse: jr target not word-aligned.
illegal_jump  output  1  one-cycle pulse: jump == 2'b11 on advance.
fetch_count  output  32  number of retired advances; wraps modulo 2^32.

Behaviour:
- Reset values (asynchronous):
  - state = RST; pc = RESET_PC; instr = 0; instr_valid = 0.
  - imem_req = 0; misalign_fault = 0; illegal_jump = 0; fetch_count = 0.
- FSM states: RST, FETCH, HOLD.
  - RST: first clock edge after reset deasserts -> FETCH.
  - FETCH: imem_req = 1 (decoded from state); imem_addr = pc, stable while req is high.
    - On imem_req & imem_ready: instr <= imem_rdata, instr_valid <= 1, -> HOLD.
    - Otherwise stay in FETCH for any number of wait cycles.
    - advance is ignored in FETCH.
  - HOLD: imem_req = 0; instr and pc held.
    - On advance: pc <= next_pc, instr_valid <= 0, fetch_count <= fetch_count + 1, -> FETCH.
    - Without advance: stay in HOLD indefinitely.
- Latency:
  - Zero-wait memory gives instr_valid on the cycle after imem_req.
  - Minimum 2 cycles per instruction (FETCH, HOLD with advance).
  - Each memory wait cycle adds 1.
- next_pc is combinational, used only on advance in HOLD:
  - jump == 01: {pc_plus4[31:28], jump_target, 2'b00}.
  - jump == 10: {reg_target[31:2], 2'b00}; if reg_target[1:0] != 0, misalign_fault = 1 for the following cycle.
  - jump == 00: if pc_src, pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}); otherwise pc_plus4.
  - jump == 11: pc_plus4; illegal_jump = 1 for the following cycle.
  - jump has priority over pc_src. pc_src may be X when jump != 00 and must not propagate into pc.
- Arithmetic:
  - All adds are 32-bit, modulo 2^32; pc wrap from 32'hFFFF_FFFC to 0 is legal.
  - pc_plus4 = pc + 4, combinational.
- Fault pulses are registered, asserted exactly one cycle, and deasserted otherwise.
- imem_rdata is sampled only when imem_req & imem_ready; imem_ready outside FETCH is ignored.
- Reset mid-fetch or mid-hold:
  - Immediate return to reset values; imem_req drops asynchronously.
  - Any in-flight response is discarded.

Test Plan:
- Reset, imem_ready tied 1, advance tied 1, jump = 00, pc_src = 0 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every 2nd cycle; fetch_count = 3 after third advance.
- pc = 0x10 in HOLD, imem_ready delayed 3 cycles on the next fetch; advance with jump = 00, pc_src = 1, imm = 16'hFFFF -> next pc = 0x10; imem_req held 4 cycles with stable address 0x10.
- pc = 0x1000_0000, advance with jump = 01, jump_target = 26'h000_0040 -> pc = 0x1000_0100; pc_src = X has no effect.
- Advance with jump = 10, reg_target = 0x0000_2003 -> pc = 0x0000_2000; misalign_fault high exactly one cycle. Repeat with jump = 11 at pc = 0x20 -> pc = 0x24; illegal_jump pulses once.
- Hold 5 cycles with advance = 0 -> pc and instr stable, imem_req = 0. Then assert reset mid-FETCH with imem_ready = 0 -> pc = RESET_PC, imem_req = 0 the same cycle, fetch_count = 0. A late imem_ready after reset release does not set instr_valid until the first FETCH cycle.
- pc = 0xFFFF_FFFC, sequential advance -> pc = 0x0000_0000.
